ysyx_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit that sits directly upstream of the integer register file and drives one of its write ports (`rf_wr_en`/`waddr`/`wdata`). The unit accepts one M-extension operation through a valid/ready handshake and computes it over 32 iterations. It then writes the 32-bit result to register `rd` for exactly one cycle. Writes to x0 are suppressed here because the register file does not hard-wire x0.

---
 rtl/ysyx_muldiv.sv | 149 ++++++++++++++
 tb/tb_ysyx_muldiv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over 32 cycles, one registered register-file write per operation.
module ysyx_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  input  logic            kill,
  output logic            busy,
  output logic            rf_wr_en,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          r_state;
  logic [5:0]      r_cnt;
  logic [2:0]      r_op;
  logic [4:0]      r_waddr;
  logic            r_neg;
  logic            r_wr_en;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_wdata;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic            w_accept, w_is_div, w_a_neg, w_b_neg, w_neg_res;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_min, w_a_mag, w_b_mag, w_spec_val;

  assign w_accept  = (r_state == IDLE) && in_valid && !kill;
  assign w_is_div  = op[2];
  assign w_min     = {1'b1, {(XLEN-1){1'b0}}};
  assign w_a_neg   = !(op inside {3'd3, 3'd5, 3'd7}) && rs1_data[XLEN-1];
  assign w_b_neg   = (op inside {3'd0, 3'd1, 3'd4, 3'd6}) && rs2_data[XLEN-1];
  assign w_a_mag   = cond_neg(rs1_data, w_a_neg);
  assign w_b_mag   = cond_neg(rs2_data, w_b_neg);
  // remainder follows the dividend sign, everything else the xor of the signs
  assign w_neg_res = (w_is_div && op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_div0    = w_is_div && (rs2_data == '0);
  assign w_ovf     = w_is_div && !op[0] && (rs1_data == w_min) && (&rs2_data);
  assign w_special = w_div0 || w_ovf;
  assign w_spec_val = w_div0 ? (op[1] ? rs1_data : '1) : (op[1] ? '0 : w_min);

  // ---- iteration step: multiply (hi:lo accumulator) or divide (hi = remainder, lo = quotient)
  logic [XLEN:0]     w_sum, w_shift, w_trial;
  logic              w_qbit;
  logic [XLEN-1:0]   w_hi_n, w_lo_n, w_res;
  logic [2*XLEN-1:0] w_prod;

  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_a};
  assign w_qbit  = !w_trial[XLEN];
  assign w_hi_n  = r_op[2] ? (w_qbit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0]) : w_sum[XLEN:1];
  assign w_lo_n  = r_op[2] ? {r_lo[XLEN-2:0], w_qbit} : {w_sum[0], r_lo[XLEN-1:1]};
  assign w_prod  = cond_neg_w({w_hi_n, w_lo_n}, r_neg);

  always_comb begin
    w_res = '0;
    case (r_op)
      3'd0:                w_res = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    w_res = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          w_res = cond_neg(w_lo_n, r_neg);
      default:             w_res = cond_neg(w_hi_n, r_neg);
    endcase
  end

  // ---- operand / accumulator registers
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a   <= w_is_div ? w_b_mag : w_a_mag;
      r_lo  <= w_is_div ? w_a_mag : w_b_mag;
      r_hi  <= '0;
      r_op  <= op;
      r_neg <= w_neg_res;
    end else if (r_state == CALC) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
    end
  end

  // ---- control and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr_en <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_waddr <= rd;
            r_cnt   <= 6'd32;
            if (w_special) begin
              r_state <= DONE;
              r_wdata <= w_spec_val;
              r_wr_en <= (rd != 5'd0);
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) begin
              r_state <= DONE;
              r_wdata <= w_res;
              r_wr_en <= (r_waddr != 5'd0);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_wr_en <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  // a flush in the DONE cycle must still cancel the write
  assign rf_wr_en = r_wr_en && !kill;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;

endmodule

// File: tb/tb_ysyx_muldiv.sv
// Bench for ysyx_muldiv: directed RV32M vectors against an arithmetic reference
// model plus a per-cycle transaction-level model of the handshake and write port.
module tb_ysyx_muldiv;

  logic        clk = 1'b0;
  logic        rst, in_valid, kill;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd;
  logic        in_ready, busy, rf_wr_en;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  ysyx_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .kill(kill), .busy(busy),
    .rf_wr_en(rf_wr_en), .waddr(waddr), .wdata(wdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference straight from the RV32M definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int ia, ib;
    ia = a;
    ib = b;
    case (o)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
      3'd2: begin p = longint'($signed(a)) * longint'({32'h0, b}); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Transaction model: cycles left until idle, expected write-port contents.
  int          m_left;
  logic [31:0] m_exp, m_wd;
  logic [4:0]  m_rd, m_wa;
  bit          m_fresh;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_wd = '0; m_wa = '0; m_rd = '0; m_fresh = 1'b1;
    end else if (m_left != 0) begin
      if (kill) m_left = 0;
      else begin
        m_left--;
        if (m_left == 1) m_wd = m_exp;
      end
    end else if (in_valid && !kill) begin
      m_exp   = ref_result(op, rs1_data, rs2_data);
      m_rd    = rd;
      m_wa    = rd;
      m_fresh = 1'b0;
      m_left  = latency(op, rs1_data, rs2_data);
      if (m_left == 1) m_wd = m_exp;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'h0, in_ready}, {31'h0, m_left == 0});
      chk("busy", {31'h0, busy}, {31'h0, m_left != 0});
      chk("rf_wr_en", {31'h0, rf_wr_en}, {31'h0, (m_left == 1) && (m_rd != 0) && !kill});
      chk("wdata_reg", wdata, m_wd);
      if (m_left == 1 || (m_left == 0 && m_fresh))
        chk("waddr", {27'h0, waddr}, {27'h0, m_wa});
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; rs1_data = a; rs2_data = b; rd = r;
    @(posedge clk); #1;
  endtask

  // Called in cycle `startc` (just after an edge); waits for the write or for idle when rd==0.
  task automatic wait_result(input string nm, input int startc, input int lat,
                             input logic [4:0] r, input logic [31:0] lit);
    int seen = 0;
    for (int c = startc; c <= 40; c++) begin
      @(negedge clk);
      if ((r == 0) ? !busy : rf_wr_en) begin seen = c; break; end
    end
    if (r != 0) begin
      chk({nm, "_cycle"}, 32'(seen), 32'(lat));
      chk({nm, "_wdata"}, wdata, lit);
      chk({nm, "_waddr"}, {27'h0, waddr}, {27'h0, r});
      @(posedge clk); #1;
      chk({nm, "_ready_after"}, {31'h0, in_ready}, 32'h1);
    end else begin
      chk({nm, "_idle_cycle"}, 32'(seen), 32'(lat + 1));
      chk({nm, "_wdata"}, wdata, lit);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input logic [31:0] lit);
    chk({nm, "_model"}, ref_result(o, a, b), lit);
    issue(o, a, b, r);
    in_valid = 1'b0;
    wait_result(nm, 1, latency(o, a, b), r, lit);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; op = '0;
    rs1_data = '0; rs2_data = '0; rd = '0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_wr_en", {31'h0, rf_wr_en}, 32'h0);
    chk("rst_waddr", {27'h0, waddr}, 32'h0);
    chk("rst_wdata", wdata, 32'h0);

    run_op("mul",      3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run_op("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE);
    run_op("mulh",     3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000);
    run_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd17, 32'h4000_0000);
    run_op("div",      3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD);
    run_op("rem",      3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF);
    run_op("divu",     3'd5, 32'd100,       32'd7,         5'd11, 32'd14);
    run_op("remu",     3'd7, 32'd100,       32'd7,         5'd12, 32'd2);
    run_op("div_n100", 3'd4, 32'hFFFF_FF9C, 32'd7,         5'd18, 32'hFFFF_FFF2);
    run_op("rem_n100", 3'd6, 32'hFFFF_FF9C, 32'd7,         5'd19, 32'hFFFF_FFFE);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000);
    run_op("divu_z",   3'd5, 32'h0000_1234, 32'h0000_0000, 5'd15, 32'hFFFF_FFFF);
    run_op("remu_z",   3'd7, 32'h0000_1234, 32'h0000_0000, 5'd16, 32'h0000_1234);
    run_op("rem_z",    3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 5'd20, 32'hFFFF_FFFB);
    run_op("mul_x0",   3'd0, 32'h0001_0001, 32'h0001_0001, 5'd0,  32'h0002_0001);

    // kill while idle blocks the accept
    @(posedge clk); #1;
    in_valid = 1'b1; kill = 1'b1; op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd4; rd = 5'd21;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    chk("kill_idle_ready", {31'h0, in_ready}, 32'h1);
    chk("kill_idle_busy", {31'h0, busy}, 32'h0);

    // kill in CALC cycle 10
    issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_ready_c11", {31'h0, in_ready}, 32'h1);
    chk("kill_busy_c11", {31'h0, busy}, 32'h0);
    repeat (40) @(posedge clk);
    #1;

    // in_valid held during CALC with changing operands: no re-accept
    issue(3'd5, 32'd100, 32'd7, 5'd22);
    rs1_data = 32'd55;
    repeat (19) @(posedge clk);
    #1;
    chk("hold_ready_c20", {31'h0, in_ready}, 32'h0);
    in_valid = 1'b0;
    wait_result("hold", 20, 33, 5'd22, 32'd14);

    // reset in CALC cycle 20
    issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    chk("mrst_wr_en", {31'h0, rf_wr_en}, 32'h0);
    chk("mrst_waddr", {27'h0, waddr}, 32'h0);
    chk("mrst_wdata", wdata, 32'h0);
    repeat (20) @(posedge clk);
    #1;

    run_op("post_rst", 3'd5, 32'd100, 32'd7, 5'd11, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
